// File: rtl/div_ctrl_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_ctrl_if
// Start/ready handshake and operand/result bundle for the execute-stage divide
// sequencer (div_ctrl).
//   start_i  : divide instruction present in execute, held high while stalled
//   signed_i : 1 = two's complement divide, 0 = unsigned divide
//   annul_i  : execute-stage flush, aborts any operation in flight
//   a_i, b_i : dividend / divisor, sampled only when a start is accepted
//   ready_o  : one-cycle result-valid pulse
//   busy_o   : iteration in progress
//   result_o : {HI = remainder, LO = quotient}, held until the next completion
// Modports: master = pipeline / hazard side, slave = div_ctrl.
// -----------------------------------------------------------------------------
interface div_ctrl_if;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        ready_o;
    logic        busy_o;
    logic [63:0] result_o;

    modport master (
        output start_i, signed_i, annul_i, a_i, b_i,
        input  ready_o, busy_o, result_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, a_i, b_i,
        output ready_o, busy_o, result_o
    );
endinterface

// File: rtl/div_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle 32-bit divide sequencer (radix-2 restoring, 32 iterations).
// Accepts a request in IDLE, iterates for 32 cycles in BUSY, and presents the
// sign-corrected {remainder, quotient} with a one-cycle ready pulse in DONE.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : div_ctrl_if.slave (start/signed/annul/operands in, ready/busy/
//            result out)
// Build option:
//   DIV_ZERO_FAST_EN : when defined, a zero divisor skips the iterations and
//                      goes straight from IDLE to DONE.
// -----------------------------------------------------------------------------
module div_ctrl (
    input  logic         clk,
    input  logic         resetn,
    div_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] dvd_reg, dvd_next;     // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_reg, rem_next;     // partial remainder (always < divisor)
    logic [31:0] dsr_reg, dsr_next;     // divisor magnitude
    logic [4:0]  cnt_reg, cnt_next;
    logic        q_neg_reg, q_neg_next;
    logic        r_neg_reg, r_neg_next;
    logic        zero_reg, zero_next;
    logic [31:0] a_raw_reg, a_raw_next; // original dividend, returned as HI on /0
    logic [63:0] result_reg, result_next;

    // Operand magnitudes. The magnitude of -2^31 is 2^31, which still fits an
    // unsigned 32-bit value, so the 0x8000_0000 / -1 case wraps naturally.
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;

    assign a_neg = bus.signed_i & bus.a_i[31];
    assign b_neg = bus.signed_i & bus.b_i[31];
    assign a_abs = a_neg ? (~bus.a_i + 32'd1) : bus.a_i;
    assign b_abs = b_neg ? (~bus.b_i + 32'd1) : bus.b_i;

    // One restoring step. The shifted partial remainder is 33 bits; when its
    // top bit is set it exceeds any 32-bit divisor, so the subtract always
    // succeeds and its true result fits in 32 bits.
    logic [32:0] rem_sh;
    logic [31:0] trial;
    logic        borrow;
    logic        q_bit;
    logic [31:0] rem_step, dvd_step;
    logic [31:0] q_fix, r_fix;
    logic [63:0] final_res;

    always_comb begin
        rem_sh          = {rem_reg, dvd_reg[31]};
        {borrow, trial} = {1'b0, rem_sh[31:0]} - {1'b0, dsr_reg};
        q_bit           = rem_sh[32] | ~borrow;
        rem_step        = q_bit ? trial : rem_sh[31:0];
        dvd_step        = {dvd_reg[30:0], q_bit};
        q_fix           = q_neg_reg ? (~dvd_step + 32'd1) : dvd_step;
        r_fix           = r_neg_reg ? (~rem_step + 32'd1) : rem_step;
        final_res       = zero_reg ? {a_raw_reg, 32'hFFFF_FFFF} : {r_fix, q_fix};
    end

    // Next-state and datapath control.
    always_comb begin
        state_next  = state_reg;
        dvd_next    = dvd_reg;
        rem_next    = rem_reg;
        dsr_next    = dsr_reg;
        cnt_next    = cnt_reg;
        q_neg_next  = q_neg_reg;
        r_neg_next  = r_neg_reg;
        zero_next   = zero_reg;
        a_raw_next  = a_raw_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    dvd_next   = a_abs;
                    dsr_next   = b_abs;
                    rem_next   = 32'd0;
                    cnt_next   = 5'd0;
                    q_neg_next = a_neg ^ b_neg;
                    r_neg_next = a_neg;
                    zero_next  = (bus.b_i == 32'd0);
                    a_raw_next = bus.a_i;
                    state_next = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.b_i == 32'd0) begin
                        state_next  = DONE;
                        result_next = {bus.a_i, 32'hFFFF_FFFF};
                    end
`else
`endif
                end
            end
            BUSY: begin
                dvd_next = dvd_step;
                rem_next = rem_step;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    // Result lands on the DONE-entry edge, even if annulled.
                    state_next  = DONE;
                    result_next = final_res;
                end
                if (bus.annul_i) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                // The same instruction is still in execute: start is ignored.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            dvd_reg    <= 32'd0;
            rem_reg    <= 32'd0;
            dsr_reg    <= 32'd0;
            cnt_reg    <= 5'd0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            a_raw_reg  <= 32'd0;
            result_reg <= 64'd0;
        end else begin
            state_reg  <= state_next;
            dvd_reg    <= dvd_next;
            rem_reg    <= rem_next;
            dsr_reg    <= dsr_next;
            cnt_reg    <= cnt_next;
            q_neg_reg  <= q_neg_next;
            r_neg_reg  <= r_neg_next;
            zero_reg   <= zero_next;
            a_raw_reg  <= a_raw_next;
            result_reg <= result_next;
        end
    end

    // Outputs are pure decodes of registered state.
    assign bus.ready_o  = (state_reg == DONE);
    assign bus.busy_o   = (state_reg == BUSY);
    assign bus.result_o = result_reg;

endmodule
